counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Controller that sequences an external free-running counter (sync reset, enable, registered `count` output) through programmed counting periods. It latches a terminal value and repeat count over a valid/ready config handshake, then drives the counter's reset/enable lines to run one or more periods of `terminal+1` enabled cycles. It emits per-period `tick` and end-of-burst `done` pulses. It sits between the control/register logic and the counter instance.

## Interface
- `WIDTH`, 8, counter width; must match the controlled counter.
- `REPEAT_W`, 4, width of the repeat count.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  config offer.
- `cfg_ready`  out  1  config accepted when high with `cfg_valid`; high only in IDLE.
- `cfg_terminal`  in  WIDTH  last count value of a period.
- `cfg_repeat`  in  REPEAT_W  periods per run; 0 = continuous.
- `start`  in  1  single-cycle run request.
- `stop`  in  1  single-cycle abort request.
- `hold`  in  1  level-sensitive pause.
- `cnt_reset`  out  1  drives the counter's reset.
- `cnt_enable`  out  1  drives the counter's enable.
- `cnt_value`  in  WIDTH  counter output; updates one cycle after `cnt_reset`/`cnt_enable`.
- `busy`  out  1  high in RUN.
- `tick`  out  1  one-cycle pulse on each completed period.
- `done`  out  1  one-cycle pulse on completion of the final period.
- `periods_left`  out  REPEAT_W  remaining periods; 0 when idle or continuous.

## Operation
- States: IDLE and RUN; state is registered.
- Reset:
  - State goes to IDLE, `term_q` to all ones, `rep_q` to 0, `periods_left` to 0.
  - During and after reset: `cnt_reset=1`, `cnt_enable=0`, `cfg_ready=1`, `busy=tick=done=0`.
- IDLE:
  - `cnt_reset=1`, which keeps the counter at 0.
  - `cfg_valid&&cfg_ready` latches `term_q<=cfg_terminal` and `rep_q<=cfg_repeat`.
  - `start` moves to RUN and loads `periods_left<=rep_q`. If a config is accepted in the same cycle, the new values are used.
  - `stop` and `hold` are ignored.
- RUN:
  - `cnt_enable = !hold && !stop`.
  - Terminal condition: `cnt_value==term_q && !hold && !stop`. On terminal:
    - `tick=1` and `cnt_reset=1`; counter reset wins, so the next value is 0.
    - If `periods_left==1`: `done=1`, `periods_left<=0`, go to IDLE.
    - Else if `periods_left>1`: decrement.
    - If `periods_left==0` (continuous): no change, stay in RUN.
  - `stop`: `cnt_reset=1`, `cnt_enable=0`, go to IDLE, `periods_left<=0`; no `tick` or `done`. `stop` has priority over terminal and `hold`.
  - `hold=1`: counter frozen, no terminal detection, state unchanged.
  - `start` and `cfg_valid` are ignored (`cfg_ready=0`).
- Equality compare only. If `cnt_value>term_q`, which is unreachable in normal use, the counter wraps modulo 2^WIDTH before matching.

## Timing
- `cnt_reset`, `cnt_enable`, `tick` and `done` are combinational from registered state, `term_q`, `periods_left`, `cnt_value`, `hold` and `stop`. There is no loop because the counter is registered.
- `busy`, `cfg_ready` and `periods_left` are registered.
- Start latency: `start` at cycle N puts RUN in cycle N+1 with `cnt_value=0`.
- Period length: `term_q+1` non-held RUN cycles; `tick` is asserted in the cycle `cnt_value==term_q`.
- `term_q=0`: `tick` every non-held RUN cycle.
- The cycle after `done` or `stop` is IDLE with `cfg_ready=1`; a new `start` is accepted there.
- `reset` mid-run: next cycle is IDLE with reset values; `tick`/`done` are suppressed in the reset cycle.

## Configuration
- `COUNTER_SEQ_AUTOSTART_EN` defined: accepting a config in IDLE also starts the run, exactly as if `start` were asserted that cycle. A run then begins from `cfg_valid` alone.
- Not defined: a config is only latched; `start` is required to begin a run.

## Test plan
- After reset: `cnt_reset=1`, `cnt_enable=0`, `cfg_ready=1`, `busy=0`, `periods_left=0`.
- Config term=3, repeat=2, then `start` → `tick` at RUN cycles 4 and 8, `done` at cycle 8, IDLE in cycle 9, `periods_left` goes 2→1→0.
- Continuous (repeat=0), term=1 → `tick` every 2nd cycle with no `done`. `hold` high for 3 cycles freezes `cnt_value` and delays the next `tick` by 3.
- `stop` asserted in the same cycle `cnt_value==term_q` → no `tick`/`done`, IDLE next cycle, counter 0.
- `cfg_valid` asserted with new term in RUN → ignored (`cfg_ready=0`). `reset` mid-run → IDLE, term reset to 255.
- With `COUNTER_SEQ_AUTOSTART_EN`: `cfg_valid` in IDLE → RUN next cycle without `start`. Without the macro: stays IDLE.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer
//
// Sequences an external free-running counter (sync reset, enable, registered
// count) through programmed counting periods of terminal+1 enabled cycles.
// A terminal value and repeat count are latched over a valid/ready handshake
// in IDLE; a start request then runs one or more periods (repeat=0 runs
// continuously) emitting a tick per period and a done pulse after the last.
//
// Optional feature: define COUNTER_SEQ_AUTOSTART_EN to make an accepted
// config in IDLE also start the run, exactly as if start were asserted.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   cfg_valid/ready   config handshake (ready high only in IDLE)
//   cfg_terminal      last count value of a period
//   cfg_repeat        periods per run, 0 = continuous
//   start, stop       single-cycle run / abort requests
//   hold              level-sensitive pause
//   cnt_reset/enable  drive the controlled counter
//   cnt_value         counter output (registered in the counter)
//   busy              high in RUN
//   tick, done        per-period and end-of-burst pulses
//   periods_left      remaining periods (0 when idle or continuous)
module counter_sequencer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned REPEAT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WIDTH-1:0]    cfg_terminal,
  input  logic [REPEAT_W-1:0] cfg_repeat,
  input  logic                start,
  input  logic                stop,
  input  logic                hold,
  output logic                cnt_reset,
  output logic                cnt_enable,
  input  logic [WIDTH-1:0]    cnt_value,
  output logic                busy,
  output logic                tick,
  output logic                done,
  output logic [REPEAT_W-1:0] periods_left
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [REPEAT_W-1:0] ONE = REPEAT_W'(1);

  state_t              state;
  logic [WIDTH-1:0]    term_q;
  logic [REPEAT_W-1:0] rep_q;

  logic running;
  logic term_hit;
  logic accept;
  logic go;

  // Counter controls and pulses are combinational; the counter itself is
  // registered, so cnt_value -> cnt_reset does not form a loop.
  always_comb begin
    running    = (state == RUN);
    term_hit   = running && !hold && !stop && (cnt_value == term_q);
    cnt_enable = !reset && running && !hold && !stop;
    // Counter reset wins over enable on terminal, so the next value is 0.
    cnt_reset  = reset || !running || stop || term_hit;
    tick       = !reset && term_hit;
    done       = !reset && term_hit && (periods_left == ONE);
    accept     = !running && cfg_valid && cfg_ready;
`ifdef COUNTER_SEQ_AUTOSTART_EN
    go         = !running && (start || accept);
`else
    go         = !running && start;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      term_q       <= '1;
      rep_q        <= '0;
      periods_left <= '0;
      busy         <= 1'b0;
      cfg_ready    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            term_q <= cfg_terminal;
            rep_q  <= cfg_repeat;
          end
          if (go) begin
            state        <= RUN;
            // A config accepted alongside start takes effect immediately.
            periods_left <= accept ? cfg_repeat : rep_q;
            busy         <= 1'b1;
            cfg_ready    <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state        <= IDLE;
            periods_left <= '0;
            busy         <= 1'b0;
            cfg_ready    <= 1'b1;
          end else if (term_hit) begin
            if (periods_left == ONE) begin
              state        <= IDLE;
              periods_left <= '0;
              busy         <= 1'b0;
              cfg_ready    <= 1'b1;
            end else if (periods_left > ONE) begin
              periods_left <= periods_left - ONE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Testbench for counter_sequencer: external counter plus a period-position
// reference model checked every cycle, and directed scenarios with
// hand-computed expectations.
module tb_counter_sequencer;

`ifdef COUNTER_SEQ_AUTOSTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_terminal = '0;
  logic [3:0] cfg_repeat = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       hold = 1'b0;
  logic       cnt_reset;
  logic       cnt_enable;
  logic [7:0] cnt_value = '0;
  logic       busy;
  logic       tick;
  logic       done;
  logic [3:0] periods_left;

  int n_cmp = 0;
  int n_bad = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(8), .REPEAT_W(4)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_terminal(cfg_terminal), .cfg_repeat(cfg_repeat), .start(start),
    .stop(stop), .hold(hold), .cnt_reset(cnt_reset), .cnt_enable(cnt_enable),
    .cnt_value(cnt_value), .busy(busy), .tick(tick), .done(done),
    .periods_left(periods_left)
  );

  // The controlled counter.
  always @(posedge clk) begin
    if (cnt_reset) cnt_value <= '0;
    else if (cnt_enable) cnt_value <= cnt_value + 8'd1;
  end

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endfunction

  // Reference model: run flag, latched config, periods remaining and the
  // position inside the current period.
  bit m_run = 1'b0;
  int m_term = 255;
  int m_rep = 0;
  int m_left = 0;
  int m_pos = 0;

  always @(negedge clk) begin
    if (model_on) begin
      bit hit;
      bit e_rst, e_en;
      hit   = !reset && m_run && !stop && !hold && (m_pos == m_term);
      e_en  = !reset && m_run && !stop && !hold;
      e_rst = reset || !m_run || stop || hit;
      chk("m_cfg_ready", cfg_ready, !m_run);
      chk("m_busy", busy, m_run);
      chk("m_periods_left", periods_left, m_left);
      chk("m_cnt_value", cnt_value, m_pos);
      chk("m_cnt_reset", cnt_reset, e_rst);
      chk("m_cnt_enable", cnt_enable, e_en);
      chk("m_tick", tick, hit);
      chk("m_done", done, hit && m_left == 1);
      if (reset) begin
        m_run = 0; m_term = 255; m_rep = 0; m_left = 0; m_pos = 0;
      end else if (!m_run) begin
        bit go;
        go = start || (AUTO && cfg_valid);
        if (go) m_left = cfg_valid ? int'(cfg_repeat) : m_rep;
        if (cfg_valid) begin
          m_term = int'(cfg_terminal);
          m_rep  = int'(cfg_repeat);
        end
        m_run = go;
        m_pos = 0;
      end else if (stop) begin
        m_run = 0; m_left = 0; m_pos = 0;
      end else if (!hold) begin
        if (hit) begin
          m_pos = 0;
          if (m_left == 1) begin
            m_run = 0; m_left = 0;
          end else if (m_left > 1) begin
            m_left--;
          end
        end else begin
          m_pos = (m_pos + 1) % 256;
        end
      end
    end
  end

  // Advance one cycle: inputs set beforehand apply to the cycle whose
  // outputs are visible on return (sampled at the falling edge).
  logic o_tick, o_done, o_busy, o_ready, o_rst, o_en;
  logic [7:0] o_cnt;
  logic [3:0] o_left;
  task automatic next();
    @(negedge clk);
    o_tick = tick; o_done = done; o_busy = busy; o_ready = cfg_ready;
    o_rst = cnt_reset; o_en = cnt_enable; o_cnt = cnt_value; o_left = periods_left;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_start(input logic [7:0] t, input logic [3:0] r);
    cfg_valid = 1; cfg_terminal = t; cfg_repeat = r; start = 1;
    next();
    cfg_valid = 0; start = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    model_on = 1'b1;
    next();
    chk("reset_cnt_reset", o_rst, 1);
    chk("reset_cnt_enable", o_en, 0);
    chk("reset_cfg_ready", o_ready, 1);
    chk("reset_busy", o_busy, 0);
    chk("reset_periods_left", o_left, 0);
    reset = 0;
    next();
    chk("idle_cnt_reset", o_rst, 1);
    chk("idle_cfg_ready", o_ready, 1);

    // term=3, repeat=2
    cfg_start(8'd3, 4'd2);
    for (int i = 1; i <= 9; i++) begin
      next();
      chk("a_tick", o_tick, (i == 4 || i == 8));
      chk("a_done", o_done, (i == 8));
      chk("a_busy", o_busy, (i <= 8));
      chk("a_left", o_left, (i <= 4) ? 2 : (i <= 8) ? 1 : 0);
      chk("a_cnt", o_cnt, (i <= 8) ? (i - 1) % 4 : 0);
    end

    // term=0: tick every run cycle
    cfg_start(8'd0, 4'd3);
    for (int i = 1; i <= 4; i++) begin
      next();
      chk("b_tick", o_tick, (i <= 3));
      chk("b_done", o_done, (i == 3));
      chk("b_busy", o_busy, (i <= 3));
    end

    // continuous term=1, hold for 3 cycles, then stop on the terminal cycle
    cfg_start(8'd1, 4'd0);
    for (int i = 1; i <= 6; i++) begin
      next();
      chk("c_tick", o_tick, (i % 2 == 0));
      chk("c_done", o_done, 0);
      chk("c_left", o_left, 0);
    end
    hold = 1;
    for (int i = 7; i <= 9; i++) begin
      next();
      chk("c_hold_cnt", o_cnt, 0);
      chk("c_hold_tick", o_tick, 0);
      chk("c_hold_en", o_en, 0);
    end
    hold = 0;
    next();
    chk("c_resume_tick", o_tick, 0);
    next();
    chk("c_delayed_tick", o_tick, 1);
    chk("c_delayed_cnt", o_cnt, 1);
    next();
    stop = 1;
    next();
    chk("c_stop_cnt", o_cnt, 1);
    chk("c_stop_tick", o_tick, 0);
    chk("c_stop_done", o_done, 0);
    chk("c_stop_rst", o_rst, 1);
    stop = 0;
    next();
    chk("c_after_busy", o_busy, 0);
    chk("c_after_ready", o_ready, 1);
    chk("c_after_cnt", o_cnt, 0);

    // config offered in RUN is ignored
    cfg_start(8'd5, 4'd1);
    for (int i = 1; i <= 7; i++) begin
      if (i == 2) begin
        cfg_valid = 1; cfg_terminal = 8'd1; cfg_repeat = 4'd3;
      end
      next();
      cfg_valid = 0;
      if (i == 2) chk("d_ready_in_run", o_ready, 0);
      chk("d_tick", o_tick, (i == 6));
      chk("d_done", o_done, (i == 6));
      chk("d_busy", o_busy, (i <= 6));
    end

    // reset mid-run on the terminal cycle
    start = 1; next(); start = 0;
    for (int i = 1; i <= 5; i++) next();
    reset = 1;
    next();
    chk("e_reset_cnt", o_cnt, 5);
    chk("e_reset_tick", o_tick, 0);
    chk("e_reset_done", o_done, 0);
    chk("e_reset_en", o_en, 0);
    reset = 0;
    next();
    chk("e_after_busy", o_busy, 0);
    chk("e_after_ready", o_ready, 1);
    chk("e_after_left", o_left, 0);

    // terminal back at 255, repeat 0 after reset
    start = 1; next(); start = 0;
    for (int i = 1; i <= 257; i++) begin
      next();
      chk("f_tick", o_tick, (i == 256));
      chk("f_cnt", o_cnt, (i - 1) % 256);
    end
    stop = 1; next(); stop = 0;
    next();
    chk("f_after_busy", o_busy, 0);

    // config without start: autostart only when enabled
    cfg_valid = 1; cfg_terminal = 8'd2; cfg_repeat = 4'd1;
    next();
    cfg_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      next();
      chk("g_auto_busy", o_busy, AUTO && i <= 3);
      chk("g_auto_done", o_done, AUTO && i == 3);
    end
    start = 1; next(); start = 0;
    for (int i = 1; i <= 4; i++) begin
      next();
      chk("g_done", o_done, (i == 3));
      chk("g_busy", o_busy, (i <= 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
